// File: rtl/serial_frame_tx.sv
// Framed serial transmitter: start bit (0), WIDTH data bits LSB first, stop bit (1).
// The line idles high and every bit is held for CLKS_PER_BIT clocks.
module serial_frame_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;
  logic [BW-1:0]    bitCnt_q;
  logic [TW-1:0]    tickCnt_q;
  logic             tx_q;
  logic             busy_q;
  logic             done_q;
  logic             bitEnd;
  logic             accept;

  assign in_ready = (state_q == IDLE) && !rst;
  assign accept   = in_valid && in_ready;
  assign bitEnd   = (tickCnt_q == TICK_LAST);
  assign shift_d  = shift_q >> 1;

  // tx is registered, so the next line value is loaded at the same edge the state advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bitCnt_q  <= '0;
      tickCnt_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (accept) begin
            state_q   <= START;
            shift_q   <= in_data;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
            tickCnt_q <= '0;
            bitCnt_q  <= '0;
          end
        end
        START: begin
          if (bitEnd) begin
            tickCnt_q <= '0;
            state_q   <= DATA;
            tx_q      <= shift_q[0];
          end else begin
            tickCnt_q <= tickCnt_q + TW'(1);
          end
        end
        DATA: begin
          if (bitEnd) begin
            tickCnt_q <= '0;
            shift_q   <= shift_d;
            if (bitCnt_q == BIT_LAST) begin
              bitCnt_q <= '0;
              state_q  <= STOP;
              tx_q     <= 1'b1;
            end else begin
              bitCnt_q <= bitCnt_q + BW'(1);
              tx_q     <= shift_d[0];
            end
          end else begin
            tickCnt_q <= tickCnt_q + TW'(1);
          end
        end
        STOP: begin
          if (bitEnd) begin
            tickCnt_q <= '0;
            state_q   <= IDLE;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
          end else begin
            tickCnt_q <= tickCnt_q + TW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: a queue-based line model checked every cycle, plus
// hand-computed waveforms for two parameter sets (8 bits x 2 clocks, 1 bit x 1 clock).
module tb_serial_frame_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst8, v8, ready8, tx8, busy8, done8;
  logic [7:0] d8;
  logic       rst1, v1, ready1, tx1, busy1, done1;
  logic [0:0] d1;

  int  testsRun    = 0;
  int  testsFailed = 0;
  int  cyc         = 0;
  bit  checkEn     = 1'b0;
  int  a, a1, a2, doneSeen;
  logic [9:0] litA5;
  logic [2:0] lit1;

  serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(2)) dut8 (
    .clk(clk), .rst(rst8), .in_valid(v8), .in_data(d8),
    .in_ready(ready8), .tx(tx8), .busy(busy8), .done(done8)
  );

  serial_frame_tx #(.WIDTH(1), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst1), .in_valid(v1), .in_data(d1),
    .in_ready(ready1), .tx(tx1), .busy(busy1), .done(done1)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Line value at position pos of a frame: 0 = start, 1..w = data LSB first, w+1 = stop.
  function automatic logic frameBit(input logic [7:0] d, input int w, input int pos);
    if (pos == 0) return 1'b0;
    if (pos > w) return 1'b1;
    return d[pos-1];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic [7:0] d);
    @(posedge clk);
    #1;
    rst8 = r;
    v8   = v;
    d8   = d;
  endtask

  // Returns one time unit after the edge at which the selected instance took its word.
  task automatic waitAccept(input int which, output int cycAt);
    int n;
    n = 0;
    while (((which == 8) ? ready8 : ready1) !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) checkOutput("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    cycAt = cyc;
  endtask

  // Models: each accepted word becomes a queue of per-cycle line values.
  logic q8[$];
  logic mTx8 = 1'b1, mBusy8 = 1'b0, mDone8 = 1'b0;
  always @(posedge clk) begin
    if (rst8) begin
      q8.delete();
      mTx8 = 1'b1; mBusy8 = 1'b0; mDone8 = 1'b0;
    end else begin
      if (v8 && !mBusy8)
        for (int p = 0; p < 10; p++)
          for (int k = 0; k < 2; k++) q8.push_back(frameBit(d8, 8, p));
      if (q8.size() > 0) begin
        mDone8 = 1'b0; mTx8 = q8.pop_front(); mBusy8 = 1'b1;
      end else begin
        mDone8 = mBusy8; mTx8 = 1'b1; mBusy8 = 1'b0;
      end
    end
  end

  logic q1[$];
  logic mTx1 = 1'b1, mBusy1 = 1'b0, mDone1 = 1'b0;
  always @(posedge clk) begin
    if (rst1) begin
      q1.delete();
      mTx1 = 1'b1; mBusy1 = 1'b0; mDone1 = 1'b0;
    end else begin
      if (v1 && !mBusy1)
        for (int p = 0; p < 3; p++) q1.push_back(frameBit({7'd0, d1}, 1, p));
      if (q1.size() > 0) begin
        mDone1 = 1'b0; mTx1 = q1.pop_front(); mBusy1 = 1'b1;
      end else begin
        mDone1 = mBusy1; mTx1 = 1'b1; mBusy1 = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("tx8", tx8, mTx8);
      checkOutput("busy8", busy8, mBusy8);
      checkOutput("done8", done8, mDone8);
      checkOutput("ready8", ready8, !mBusy8 && !rst8);
      checkOutput("tx1", tx1, mTx1);
      checkOutput("busy1", busy1, mBusy1);
      checkOutput("done1", done1, mDone1);
      checkOutput("ready1", ready1, !mBusy1 && !rst1);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    litA5 = {1'b1, 8'hA5, 1'b0};
    lit1  = 3'b110;
    rst8 = 1'b1; v8 = 1'b1; d8 = 8'hFF;
    rst1 = 1'b1; v1 = 1'b1; d1 = 1'b1;

    // Reset held two edges with a word offered.
    @(posedge clk);
    #1;
    checkEn = 1'b1;
    @(negedge clk);
    checkOutput("rst_tx", tx8, 1);
    checkOutput("rst_ready", ready8, 0);
    checkOutput("rst_busy", busy8, 0);
    checkOutput("rst_done", done8, 0);
    @(posedge clk);
    #1;
    rst8 = 1'b0; v8 = 1'b0; rst1 = 1'b0; v1 = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("post_rst_tx", tx8, 1);
    end

    // Single frame 8'hA5.
    applyStimulus(1'b0, 1'b1, 8'hA5);
    waitAccept(8, a);
    v8 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("a5_tx", tx8, litA5[i/2]);
      checkOutput("a5_model_tx", mTx8, litA5[i/2]);
      checkOutput("a5_busy", busy8, 1);
    end
    @(negedge clk);
    checkOutput("a5_done", done8, 1);
    checkOutput("a5_ready", ready8, 1);
    checkOutput("a5_busy_end", busy8, 0);
    @(negedge clk);
    checkOutput("a5_done_once", done8, 0);

    // Back-to-back 8'h01 then 8'h80.
    applyStimulus(1'b0, 1'b1, 8'h01);
    waitAccept(8, a1);
    d8 = 8'h80;
    waitAccept(8, a2);
    v8 = 1'b0;
    checkOutput("b2b_gap", a2 - a1, 21);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) checkOutput("b2b_start", tx8, 0);
      if (i >= 2 && i < 18 && (i % 2) == 0) checkOutput("b2b_data", tx8, ((i - 2) / 2 == 7) ? 1 : 0);
      if (i == 18) checkOutput("b2b_stop", tx8, 1);
    end

    // Reset during data bit 3 of 8'h00.
    applyStimulus(1'b0, 1'b1, 8'h00);
    waitAccept(8, a);
    v8 = 1'b0;
    repeat (7) @(posedge clk);
    applyStimulus(1'b1, 1'b0, 8'h00);
    @(negedge clk);
    checkOutput("mid_bit3_tx", tx8, 0);
    checkOutput("mid_rst_ready", ready8, 0);
    applyStimulus(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    checkOutput("mid_rst_tx", tx8, 1);
    checkOutput("mid_rst_busy", busy8, 0);
    doneSeen = 0;
    repeat (25) begin
      @(negedge clk);
      if (done8 === 1'b1) doneSeen++;
    end
    checkOutput("mid_rst_no_done", doneSeen, 0);

    applyStimulus(1'b0, 1'b1, 8'hFF);
    waitAccept(8, a);
    v8 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("ff_tx", tx8, (i < 2) ? 0 : 1);
    end
    @(negedge clk);
    checkOutput("ff_done", done8, 1);

    // Idle stall.
    repeat (10) begin
      @(negedge clk);
      checkOutput("stall_tx", tx8, 1);
      checkOutput("stall_ready", ready8, 1);
      checkOutput("stall_busy", busy8, 0);
    end

    // WIDTH=1, CLKS_PER_BIT=1 instance.
    @(posedge clk);
    #1;
    v1 = 1'b1; d1 = 1'b1;
    waitAccept(1, a);
    v1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("w1_tx", tx1, lit1[i]);
      checkOutput("w1_no_done", done1, 0);
    end
    @(negedge clk);
    checkOutput("w1_done", done1, 1);
    checkOutput("w1_ready", ready1, 1);

    repeat (3) @(negedge clk);
    checkEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
- Parallel-to-serial framed transmitter: the sending end of the single-wire serial link whose receiving end captures bits into flip-flops.
- Accepts a WIDTH-bit word over a valid/ready handshake.
- Shifts the word out LSB first on one line, framed by a start bit (0) and a stop bit (1); the line idles high.
- Sits between a register-file/bus source and the serial pin.

Parameters:
WIDTH, 8, number of data bits per frame (>=1)
CLKS_PER_BIT, 2, clock cycles each bit is held on tx (>=1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
in_valid  input  1  source presents in_data
in_data  input  WIDTH  word to transmit
in_ready  output  1  block can accept a word this cycle
tx  output  1  serial line, idle high
busy  output  1  frame in progress (any state other than IDLE)
done  output  1  one-cycle pulse: frame fully transmitted

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, tx=1, done=0, busy=0.
  - Bit counter and tick counter = 0; shift register = 0.
  - Reset mid-frame aborts immediately; tx returns high on the next edge, and no done pulse is produced.
  - in_ready = (state==IDLE) && !rst, so it is 0 while rst is high.
- Handshake:
  - Transfer when in_valid && in_ready at a posedge; in_data is latched into the shift register at that edge.
  - in_valid without in_ready is ignored; the source holds it.
  - in_data is don't-care after acceptance.
- State machine (registered state; tx, busy and done are registered):
  - IDLE: tx=1. On transfer -> START, and tx=0 from that same edge.
  - START: tx=0 for CLKS_PER_BIT cycles -> DATA, with tx = shift[0].
  - DATA: each bit is held CLKS_PER_BIT cycles, then the shift register shifts right and the bit counter increments. After bit WIDTH-1 has completed -> STOP, tx=1.
  - STOP: tx=1 for CLKS_PER_BIT cycles -> IDLE. done=1 for exactly the first cycle in IDLE, i.e. registered at the edge leaving STOP.
- Timing:
  - Frame length: (WIDTH+2)*CLKS_PER_BIT cycles from the acceptance edge to the edge entering IDLE.
  - in_ready is low throughout the frame and high again in the cycle done is high.
  - Back-to-back: a word accepted in the done cycle starts its start bit at the next edge. The minimum idle gap between frames is therefore 1 cycle of tx=1, in addition to the stop bit.
- Tick counter:
  - Counts 0..CLKS_PER_BIT-1 within each bit and wraps to 0 at each bit boundary.
  - Width is clog2(CLKS_PER_BIT), minimum 1.
- Bit counter:
  - Counts 0..WIDTH-1 and wraps to 0 on entering STOP.
  - Width is clog2(WIDTH), minimum 1.
- No data is lost or duplicated.
- in_valid changes during a frame have no effect.

Test Plan:
- Reset check: assert rst 2 cycles with in_valid=1, in_data=8'hFF -> tx=1, in_ready=0, busy=0, done=0 throughout; no frame starts after rst drops until the next accepted handshake.
- Single frame (WIDTH=8, CLKS_PER_BIT=2): send 8'hA5 ->
  - tx sequence, each value 2 cycles: 0, 1,0,1,0,0,1,0,1, 1.
  - busy high 20 cycles; done pulses once; in_ready back high with done.
- Back-to-back: hold in_valid with 8'h01 then 8'h80 ->
  - second start bit begins exactly 1 cycle after the first stop bit ends (one extra idle-high cycle).
  - second frame data bits are 0,0,0,0,0,0,0,1.
- Reset mid-frame: assert rst during data bit 3 of 8'h00 ->
  - tx=1 at the next edge; no done pulse.
  - the next word 8'hFF transmits a complete, correct frame.
- Stall: in_valid=0 for 10 cycles in IDLE -> tx stays 1, in_ready stays 1, busy=0.
- Parameter sweep: WIDTH=1, CLKS_PER_BIT=1, send 1'b1 -> tx = 0,1,1 for one cycle each; done on the 4th cycle after acceptance.
